multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32 datapath: sequences fetch/decode/execute
// steps, drives datapath strobes and mux selects, and counts retired instructions.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               ZF,
  input  logic               SF,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] state_dbg,
  output logic [31:0]        instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
  } ctrl_t;

  state_t     state_q;
  state_t     next_state;
  ctrl_t      ctrl_q;
  logic [2:0] funct_alu;
  logic       taken;
  logic       retire;
  logic [31:0] instret_q;

  // Control word for a state, computed one cycle early so outputs come from flops.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] alu_f);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
                      c.pc_update = 1'b1; end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECUTER: begin c.alu_src_a = 2'b10; c.alu_control = alu_f; end
      EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_control = alu_f; end
      ALUWB:    c.reg_write = 1'b1;
      BRANCH:   begin c.alu_src_a = 2'b10; c.alu_control = 3'b001; c.branch = 1'b1; end
      JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    funct_alu = 3'b000;
    case (funct3)
      3'b000:  funct_alu = (op[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  end

  // Unknown opcodes fall back to FETCH from DECODE; illegal codes recover the same way.
  always_comb begin
    next_state = FETCH;
    case (state_q)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_B:         next_state = BRANCH;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      JAL:      next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  assign retire = (state_q == MEMWB) || (state_q == MEMWRITE) ||
                  (state_q == ALUWB) || (state_q == BRANCH);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= FETCH;
      ctrl_q    <= decode_ctrl(FETCH, funct_alu);
      instret_q <= '0;
    end else begin
      state_q   <= next_state;
      ctrl_q    <= decode_ctrl(next_state, funct_alu);
      instret_q <= instret_q + {31'b0, retire};
    end
  end

  assign taken = ((funct3 == 3'b000) & ZF) | ((funct3 == 3'b001) & ~ZF) |
                 ((funct3 == 3'b100) & SF);

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_B:        ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  // Write strobes are gated by rst so nothing fires while reset is held.
  assign PCWrite    = ~rst & (ctrl_q.pc_update | (ctrl_q.branch & taken));
  assign IRWrite    = ~rst & ctrl_q.ir_write;
  assign MemWrite   = ~rst & ctrl_q.mem_write;
  assign RegWrite   = ~rst & ctrl_q.reg_write;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ALUControl = ctrl_q.alu_control;
  assign state_dbg  = STATE_W'(state_q);
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions
// compared against a path/table reference model of the control sequence.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        ZF;
  logic        SF;
  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state_dbg;
  logic [31:0] instret;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_instret = 0;
  logic [13:0] exp_tab [0:10];

  multicycle_ctrl #(.STATE_W(4)) dut (
    .CLK(CLK), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .ZF(ZF), .SF(SF), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state_dbg(state_dbg), .instret(instret)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] observed();
    return {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl};
  endfunction

  // Drives one held instruction from FETCH and follows it back to FETCH.
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic zf, input logic sf);
    int         path[$];
    logic [2:0] alu;
    logic       tk;
    logic [1:0] imm;
    logic [13:0] e;
    op = o; funct3 = f3; funct7b5 = f7; ZF = zf; SF = sf;
    #1;
    if (o == 7'b0000011)      begin path = {0, 1, 2, 3, 4}; imm = 2'b00; end
    else if (o == 7'b0100011) begin path = {0, 1, 2, 5};    imm = 2'b01; end
    else if (o == 7'b0110011) begin path = {0, 1, 6, 8};    imm = 2'b00; end
    else if (o == 7'b0010011) begin path = {0, 1, 7, 8};    imm = 2'b00; end
    else if (o == 7'b1100011) begin path = {0, 1, 9};       imm = 2'b10; end
    else if (o == 7'b1101111) begin path = {0, 1, 10, 8};   imm = 2'b11; end
    else                      begin path = {0, 1};          imm = 2'b00; end
    if (f3 == 3'b000)      alu = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) alu = 3'b101;
    else if (f3 == 3'b110) alu = 3'b011;
    else if (f3 == 3'b111) alu = 3'b010;
    else                   alu = 3'b000;
    tk = (f3 == 3'b000 && zf) || (f3 == 3'b001 && !zf) || (f3 == 3'b100 && sf);
    checkOutput($sformatf("immsrc op=%b", o), 32'(ImmSrc), 32'(imm));
    foreach (path[i]) begin
      e = exp_tab[path[i]];
      if (path[i] == 6 || path[i] == 7) e[2:0] = alu;
      if (path[i] == 9) e[13] = tk;
      checkOutput($sformatf("state op=%b step=%0d", o, i), 32'(state_dbg), 32'(path[i]));
      checkOutput($sformatf("ctrl op=%b f3=%b st=%0d", o, f3, path[i]), 32'(observed()), 32'(e));
      @(negedge CLK); #1;
    end
    if (path.size() > 2) exp_instret = exp_instret + 32'd1;
    checkOutput($sformatf("instret op=%b", o), instret, exp_instret);
    checkOutput($sformatf("back to fetch op=%b", o), 32'(state_dbg), 32'd0);
  endtask

  initial begin
    exp_tab[0]  = 14'b1_0_1_0_0_10_00_10_000;
    exp_tab[1]  = 14'b0_0_0_0_0_00_01_01_000;
    exp_tab[2]  = 14'b0_0_0_0_0_00_10_01_000;
    exp_tab[3]  = 14'b0_1_0_0_0_00_00_00_000;
    exp_tab[4]  = 14'b0_0_0_0_1_01_00_00_000;
    exp_tab[5]  = 14'b0_1_0_1_0_00_00_00_000;
    exp_tab[6]  = 14'b0_0_0_0_0_00_10_00_000;
    exp_tab[7]  = 14'b0_0_0_0_0_00_10_01_000;
    exp_tab[8]  = 14'b0_0_0_0_1_00_00_00_000;
    exp_tab[9]  = 14'b0_0_0_0_0_00_10_00_001;
    exp_tab[10] = 14'b1_0_0_0_0_00_01_10_000;

    rst = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; ZF = 1'b0; SF = 1'b0;
    @(negedge CLK); @(negedge CLK); #1;
    checkOutput("reset state", 32'(state_dbg), 32'd0);
    checkOutput("reset instret", instret, 32'd0);
    checkOutput("reset strobes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    checkOutput("reset alusrcb", 32'(ALUSrcB), 32'd2);

    rst = 1'b0; #1;
    checkOutput("first fetch irwrite", 32'(IRWrite), 32'd1);
    checkOutput("first fetch pcwrite", 32'(PCWrite), 32'd1);

    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0);
    applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1);
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);

    // Reset lands in the middle of a load; the load must not retire.
    op = 7'b0000011; funct3 = 3'b010; #1;
    @(negedge CLK); @(negedge CLK); @(negedge CLK); #1;
    checkOutput("midreset in memread", 32'(state_dbg), 32'd3);
    rst = 1'b1; #1;
    checkOutput("midreset strobes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    @(negedge CLK); #1;
    checkOutput("midreset state", 32'(state_dbg), 32'd0);
    checkOutput("midreset instret", instret, 32'd0);
    rst = 1'b0; #1;
    checkOutput("midreset regwrite", 32'(RegWrite), 32'd0);
    exp_instret = 32'd0;

    // Counter wrap: preload all-ones while an unknown op idles through DECODE.
    op = 7'b0000000; #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.instret_q;
    @(negedge CLK); #1;
    exp_instret = 32'hFFFF_FFFF;
    checkOutput("preload instret", instret, exp_instret);
    applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [6:0] o;
      case ($urandom_range(0, 7))
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        6: o = 7'b0000000;
        default: o = 7'($urandom_range(0, 127));
      endcase
      applyStimulus(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
